muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle unsigned 8×8 multiply/divide unit for the 8-bit CPU. It sits between the register file's read ports and its write port. It takes operands from Data1/Data2 and a destination register index, iterates for 8 cycles, and then issues a one-cycle write-back (enable, register index, data) that drives the register file's write port directly. The main single-cycle ALU is unaffected: the control unit stalls while this block is busy.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; the iteration count equals WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; returns the block to IDLE.
- start  in  1  request to begin an operation; sampled only in IDLE.
- op  in  2  operation: 00 MULLO, 01 MULHI, 10 DIVQ, 11 DIVR.
- a  in  WIDTH  multiplicand/dividend; driven from register-file Data1.
- b  in  WIDTH  multiplier/divisor; driven from register-file Data2.
- dest  in  2  destination register index.
- busy  out  1  high in RUN and WB states.
- wb_en  out  1  one-cycle write strobe to the register-file write enable.
- wb_reg  out  2  write register index, valid while wb_en is high.
- wb_data  out  WIDTH  write data, valid while wb_en is high.
- div_by_zero  out  1  pulses with wb_en when a DIV op had b==0.

## Operation
- States: IDLE, RUN, WB. Reset forces IDLE; the 3-bit iteration counter goes to 0.
- Outputs on reset: busy=0, wb_en=0, wb_reg=0, wb_data=0, div_by_zero=0.
- IDLE with start=1: latch a, b, op and dest; clear the accumulator and counter; go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN performs one iteration per cycle. After the 8th iteration (counter wraps 7→0) it goes to WB.
- MUL uses shift-add over a 2×WIDTH accumulator, producing the full 16-bit unsigned product.
  - MULLO writes product[7:0].
  - MULHI writes product[15:8].
- DIV uses restoring shift-subtract and produces an unsigned quotient and remainder.
  - DIVQ writes the quotient.
  - DIVR writes the remainder.
- Divide by zero: quotient=8'hFF, remainder=a, and div_by_zero=1 during WB. The block still takes the full 8-cycle latency.
- WB lasts exactly one cycle: wb_en=1, wb_reg=latched dest, wb_data=selected result. The next state is IDLE.
- wb_en, wb_reg, wb_data and div_by_zero are registered outputs. They are 0 in every state except WB.
- start is ignored in RUN and WB. Latched operands are not disturbed when a/b/op/dest change mid-operation.
- Reset mid-operation aborts immediately: no wb_en is ever produced for the aborted operation.

## Timing
- Edge 0: start sampled in IDLE; busy=1 from edge 0.
- Edges 1–8: iterations.
- After edge 8: WB, wb_en=1 for one cycle.
- After edge 9: IDLE, busy=0.
- The next start is accepted at edge 10 at the earliest. Throughput is one operation per 10 cycles.
- The register file captures wb_data at edge 9.

## Configuration
- Macro MULDIV_DIV_EN.
  - Defined: full behaviour as above.
  - Undefined: the divide datapath is removed. start with op[1]=1 is ignored (the block stays in IDLE, busy=0, no wb_en), and div_by_zero is tied to 0. MUL ops are unchanged.

## Structure
- Shared package muldiv_pkg holds:
  - the op_e enum (MULLO, MULHI, DIVQ, DIVR);
  - the state_e enum (IDLE, RUN, WB);
  - localparams ITER=WIDTH and DIV_ZERO_Q=8'hFF.
- Single module with no sub-module; the datapath is small enough to keep inline.

## Test plan
- a=13, b=11, MULLO, dest=2 → 8 cycles after start edge: wb_en=1, wb_reg=2, wb_data=8'h8F. Same operands with MULHI → 8'h00.
- a=8'hFF, b=8'hFF → MULLO gives 8'h01; MULHI gives 8'hFE.
- a=200, b=7 → DIVQ gives 8'h1C; DIVR gives 8'h04; div_by_zero=0.
- a=8'h37, b=0 → DIVQ gives 8'hFF with div_by_zero=1; DIVR gives 8'h37 with div_by_zero=1.
- Second start with changed a/b/dest at edge 3 of an operation → ignored: exactly one wb_en, carrying the original result and dest; busy drops after edge 9.
- reset asserted at edge 4 of a MULLO → busy=0 immediately, no wb_en. A new start after reset completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 8;
  localparam int unsigned ITER = MULDIV_WIDTH;
  localparam logic [MULDIV_WIDTH-1:0] DIV_ZERO_Q = 8'hFF;

  typedef enum logic [1:0] {
    OpMulLo = 2'b00,
    OpMulHi = 2'b01,
    OpDivQ  = 2'b10,
    OpDivR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StWb   = 2'b10
  } state_e;

  function automatic logic op_is_div(op_e op);
    return (op == OpDivQ) || (op == OpDivR);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request and register-file write-back bundle of the multiply/divide unit.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) ();

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       dest;
  logic             busy;
  logic             wb_en;
  logic [1:0]       wb_reg;
  logic [WIDTH-1:0] wb_data;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, dest,
    input  busy, wb_en, wb_reg, wb_data, div_by_zero
  );

  modport slave (
    input  start, op, a, b, dest,
    output busy, wb_en, wb_reg, wb_data, div_by_zero
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit with one-cycle write-back.
// Define MULDIV_DIV_EN to include the divide datapath; otherwise divide requests are ignored.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  op_e                op_q, op_d;
  logic [1:0]         dest_q, dest_d;
  logic               wb_en_q, wb_en_d;
  logic [1:0]         wb_reg_q, wb_reg_d;
  logic [WIDTH-1:0]   wb_data_q, wb_data_d;

  logic               accept;
  logic               last_iter;
  logic [CntW-1:0]    bit_idx;
  logic [2*WIDTH-1:0] mul_step;
  logic [2*WIDTH-1:0] iter_step;
  logic [WIDTH-1:0]   result;

  // Operand bits are consumed MSB first, so the latched operands never shift.
  assign bit_idx   = CntW'(WIDTH - 1) - cnt_q;
  assign last_iter = (cnt_q == CntW'(WIDTH - 1));
  assign mul_step  = (acc_q << 1) + {{WIDTH{1'b0}}, a_q & {WIDTH{b_q[bit_idx]}}};

`ifdef MULDIV_DIV_EN
  logic               dbz_q, dbz_d;
  logic               b_zero;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] div_step;

  // Upper half holds the partial remainder, lower half collects quotient bits.
  assign b_zero    = (b_q == '0);
  assign rem_sh    = {acc_q[2*WIDTH-1:WIDTH], a_q[bit_idx]};
  assign rem_ge    = (rem_sh >= {1'b0, b_q});
  assign rem_next  = rem_ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
  assign div_step  = {rem_next, acc_q[WIDTH-2:0], rem_ge};
  assign iter_step = op_is_div(op_q) ? div_step : mul_step;
  assign accept    = bus.start;
`else
  assign iter_step = mul_step;
  assign accept    = bus.start && !op_is_div(bus.op);
`endif

  always_comb begin
    result = mul_step[WIDTH-1:0];
    unique case (op_q)
      OpMulLo: result = mul_step[WIDTH-1:0];
      OpMulHi: result = mul_step[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
      OpDivQ:  result = b_zero ? WIDTH'(DIV_ZERO_Q) : div_step[WIDTH-1:0];
      OpDivR:  result = div_step[2*WIDTH-1:WIDTH];
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    dest_d    = dest_q;
    wb_en_d   = 1'b0;
    wb_reg_d  = '0;
    wb_data_d = '0;
`ifdef MULDIV_DIV_EN
    dbz_d     = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          dest_d  = bus.dest;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = iter_step;
        cnt_d = cnt_q + 1'b1;
        // Write-back outputs are registered, so load them on the final iteration.
        if (last_iter) begin
          state_d   = StWb;
          wb_en_d   = 1'b1;
          wb_reg_d  = dest_q;
          wb_data_d = result;
`ifdef MULDIV_DIV_EN
          dbz_d     = op_is_div(op_q) && b_zero;
`endif
        end
      end
      StWb: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OpMulLo;
      dest_q    <= '0;
      wb_en_q   <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      dest_q    <= dest_d;
      wb_en_q   <= wb_en_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
    end
  end

`ifdef MULDIV_DIV_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbz_q <= 1'b0;
    end else begin
      dbz_q <= dbz_d;
    end
  end

  assign bus.div_by_zero = dbz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif

  assign bus.busy    = (state_q != StIdle);
  assign bus.wb_en   = wb_en_q;
  assign bus.wb_reg  = wb_reg_q;
  assign bus.wb_data = wb_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; divide vectors follow the MULDIV_DIV_EN build.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   wb_cnt;

  muldiv_if #(.WIDTH(8)) bus ();

  muldiv_unit #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wb_en) wb_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Issues one operation, scrambles the inputs after acceptance and checks the write-back.
  task automatic run_op(input string tag, input op_e op, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] dest, input logic [7:0] exp_data, input logic exp_dbz);
    int lat;
    int wb0;
    wb0 = wb_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.dest  = dest;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = op_e'(~op);
    bus.a     = ~a;
    bus.b     = ~b;
    bus.dest  = ~dest;
    check_eq({tag, "_busy"}, 16'(bus.busy), 16'd1);
    lat = 0;
    while (!bus.wb_en && lat < int'(ITER) + 4) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 16'(lat), 16'(ITER));
    check_eq({tag, "_reg"}, 16'(bus.wb_reg), 16'(dest));
    check_eq({tag, "_data"}, 16'(bus.wb_data), 16'(exp_data));
    check_eq({tag, "_dbz"}, 16'(bus.div_by_zero), 16'(exp_dbz));
    @(posedge clk); #1;
    check_eq({tag, "_wb_off"}, 16'(bus.wb_en), 16'd0);
    check_eq({tag, "_idle"}, 16'(bus.busy), 16'd0);
    check_eq({tag, "_pulses"}, 16'(wb_cnt - wb0), 16'd1);
  endtask

  task automatic run_ignored(input string tag, input op_e op, input logic [7:0] a,
                             input logic [7:0] b);
    int wb0;
    wb0 = wb_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.dest  = 2'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq({tag, "_busy"}, 16'(bus.busy), 16'd0);
    repeat (12) @(posedge clk);
    #1;
    check_eq({tag, "_pulses"}, 16'(wb_cnt - wb0), 16'd0);
    check_eq({tag, "_dbz"}, 16'(bus.div_by_zero), 16'd0);
  endtask

  initial begin
    int wb0;
    checks    = 0;
    errors    = 0;
    wb_cnt    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = OpMulLo;
    bus.a     = '0;
    bus.b     = '0;
    bus.dest  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 16'(bus.busy), 16'd0);
    check_eq("rst_wb_en", 16'(bus.wb_en), 16'd0);
    check_eq("rst_wb_reg", 16'(bus.wb_reg), 16'd0);
    check_eq("rst_wb_data", 16'(bus.wb_data), 16'd0);
    check_eq("rst_dbz", 16'(bus.div_by_zero), 16'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("mullo_13x11", OpMulLo, 8'd13, 8'd11, 2'd2, 8'h8F, 1'b0);
    run_op("mulhi_13x11", OpMulHi, 8'd13, 8'd11, 2'd2, 8'h00, 1'b0);
    run_op("mullo_ffxff", OpMulLo, 8'hFF, 8'hFF, 2'd1, 8'h01, 1'b0);
    run_op("mulhi_ffxff", OpMulHi, 8'hFF, 8'hFF, 2'd3, 8'hFE, 1'b0);
    run_op("mullo_a5x3c", OpMulLo, 8'hA5, 8'h3C, 2'd0, 8'hAC, 1'b0);
    run_op("mulhi_a5x3c", OpMulHi, 8'hA5, 8'h3C, 2'd1, 8'h26, 1'b0);
    run_op("mullo_x0", OpMulLo, 8'h5A, 8'h00, 2'd2, 8'h00, 1'b0);

`ifdef MULDIV_DIV_EN
    run_op("divq_200_7", OpDivQ, 8'd200, 8'd7, 2'd1, 8'h1C, 1'b0);
    run_op("divr_200_7", OpDivR, 8'd200, 8'd7, 2'd2, 8'h04, 1'b0);
    run_op("divq_255_16", OpDivQ, 8'd255, 8'd16, 2'd3, 8'h0F, 1'b0);
    run_op("divr_255_16", OpDivR, 8'd255, 8'd16, 2'd0, 8'h0F, 1'b0);
    run_op("divq_5_9", OpDivQ, 8'd5, 8'd9, 2'd1, 8'h00, 1'b0);
    run_op("divr_5_9", OpDivR, 8'd5, 8'd9, 2'd1, 8'h05, 1'b0);
    run_op("divq_by0", OpDivQ, 8'h37, 8'h00, 2'd2, 8'hFF, 1'b1);
    run_op("divr_by0", OpDivR, 8'h37, 8'h00, 2'd3, 8'h37, 1'b1);
`else
    run_ignored("nodiv_q", OpDivQ, 8'd200, 8'd7);
    run_ignored("nodiv_r", OpDivR, 8'h37, 8'h00);
`endif

    // A second start mid-operation must not disturb the running one.
    wb0 = wb_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OpMulLo;
    bus.a     = 8'd13;
    bus.b     = 8'd11;
    bus.dest  = 2'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OpMulHi;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    bus.dest  = 2'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("restart_wb_en", 16'(bus.wb_en), 16'd1);
    check_eq("restart_reg", 16'(bus.wb_reg), 16'd2);
    check_eq("restart_data", 16'(bus.wb_data), 16'h8F);
    @(posedge clk); #1;
    check_eq("restart_idle", 16'(bus.busy), 16'd0);
    repeat (12) @(posedge clk);
    #1;
    check_eq("restart_pulses", 16'(wb_cnt - wb0), 16'd1);

    // Reset in the middle of an operation aborts it without a write-back.
    wb0 = wb_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OpMulLo;
    bus.a     = 8'd13;
    bus.b     = 8'd11;
    bus.dest  = 2'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("abort_busy", 16'(bus.busy), 16'd0);
    check_eq("abort_wb_en", 16'(bus.wb_en), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_eq("abort_pulses", 16'(wb_cnt - wb0), 16'd0);
    run_op("after_abort", OpMulLo, 8'd13, 8'd11, 2'd3, 8'h8F, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
